// File: rtl/mem_access.sv
// Memory stage of the RV64 pipeline: single-outstanding data-bus master with
// store lane alignment, load extraction/extension and a one-beat writeback.
module mem_access #(
  parameter int REG_W  = 5,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [63:0]       alu_c,
  input  logic [63:0]       st_data,
  input  logic [1:0]        mem_kind,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [REG_W-1:0]  rd,
  input  logic              flush,
  output logic              dreq_valid,
  output logic [ADDR_W-1:0] dreq_addr,
  output logic [1:0]        dreq_size,
  output logic [7:0]        dreq_strobe,
  output logic [63:0]       dreq_data,
  input  logic              dresp_addr_ok,
  input  logic              dresp_data_ok,
  input  logic [63:0]       dresp_data,
  output logic              wb_valid,
  output logic [63:0]       wb_data,
  output logic [REG_W-1:0]  wb_rd,
  output logic              wb_misalign
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] K_LOAD  = 2'd1;
  localparam logic [1:0] K_STORE = 2'd2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      SZ_B:    is_aligned = 1'b1;
      SZ_H:    is_aligned = (off[0] == 1'b0);
      SZ_W:    is_aligned = (off[1:0] == 2'b00);
      default: is_aligned = (off == 3'b000);
    endcase
  endfunction

  function automatic logic [7:0] store_strobe(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    store_strobe = base << off;
  endfunction

  function automatic logic [63:0] store_align(input logic [63:0] data, input logic [2:0] off);
    store_align = data << {off, 3'b000};
  endfunction

  // Right-justify the addressed bytes, then sign- or zero-extend to 64 bits.
  function automatic logic [63:0] load_extend(input logic [63:0] raw, input logic [1:0] size,
                                              input logic [2:0] off, input logic uns);
    logic        [63:0] t;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    logic signed [31:0] sw;
    t  = raw >> {off, 3'b000};
    sb = t[7:0];
    sh = t[15:0];
    sw = t[31:0];
    case (size)
      SZ_B:    load_extend = uns ? {56'd0, t[7:0]}  : 64'(sb);
      SZ_H:    load_extend = uns ? {48'd0, t[15:0]} : 64'(sh);
      SZ_W:    load_extend = uns ? {32'd0, t[31:0]} : 64'(sw);
      default: load_extend = t;
    endcase
  endfunction

  logic [1:0]        state_p1;
  logic [1:0]        state_nx;
  logic              kill_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [1:0]        size_p1;
  logic [7:0]        strobe_p1;
  logic [63:0]       data_p1;
  logic              load_p1;
  logic              uns_p1;
  logic [63:0]       wb_data_p2;
  logic [REG_W-1:0]  wb_rd_p2;
  logic              misalign_p2;

  logic accept;
  logic is_mem;
  logic aligned_in;
  logic bus_done;
  logic kill_now;

  assign ex_ready   = (state_p1 == S_IDLE) && !flush;
  assign accept     = ex_valid && ex_ready;
  assign is_mem     = (mem_kind == K_LOAD) || (mem_kind == K_STORE);
  assign aligned_in = is_aligned(mem_size, alu_c[2:0]);
  assign bus_done   = ((state_p1 == S_REQ) && dresp_addr_ok && dresp_data_ok) ||
                      ((state_p1 == S_WAIT) && dresp_data_ok);
  assign kill_now   = kill_p1 || flush;

  always_comb begin
    state_nx = state_p1;
    case (state_p1)
      S_IDLE: begin
        if (accept) state_nx = (is_mem && aligned_in) ? S_REQ : S_DONE;
      end
      S_REQ: begin
        if (dresp_addr_ok) begin
          if (dresp_data_ok) state_nx = kill_now ? S_IDLE : S_DONE;
          else               state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (dresp_data_ok) state_nx = kill_now ? S_IDLE : S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // A flush during the bus handshake cannot cancel it; remember it until idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p1 <= S_IDLE;
      kill_p1  <= 1'b0;
    end else begin
      state_p1 <= state_nx;
      if (state_nx == S_IDLE)
        kill_p1 <= 1'b0;
      else if (flush && ((state_p1 == S_REQ) || (state_p1 == S_WAIT)))
        kill_p1 <= 1'b1;
    end
  end

  // Request stage: fields captured on accept and held while the bus stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_p1   <= '0;
      size_p1   <= 2'd0;
      strobe_p1 <= 8'd0;
      data_p1   <= 64'd0;
      load_p1   <= 1'b0;
      uns_p1    <= 1'b0;
    end else if (accept) begin
      addr_p1   <= alu_c[ADDR_W-1:0];
      size_p1   <= mem_size;
      strobe_p1 <= (mem_kind == K_STORE) ? store_strobe(mem_size, alu_c[2:0]) : 8'd0;
      data_p1   <= (mem_kind == K_STORE) ? store_align(st_data, alu_c[2:0]) : 64'd0;
      load_p1   <= (mem_kind == K_LOAD);
      uns_p1    <= mem_unsigned;
    end
  end

  // Writeback stage: stores and good bus ops start at zero, loads overwrite on data_ok.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_data_p2  <= 64'd0;
      wb_rd_p2    <= '0;
      misalign_p2 <= 1'b0;
    end else if (accept) begin
      wb_data_p2  <= (is_mem && aligned_in) ? 64'd0 : alu_c;
      wb_rd_p2    <= rd;
      misalign_p2 <= is_mem && !aligned_in;
    end else if (bus_done && load_p1) begin
      wb_data_p2  <= load_extend(dresp_data, size_p1, addr_p1[2:0], uns_p1);
    end
  end

  assign dreq_valid  = (state_p1 == S_REQ);
  assign dreq_addr   = addr_p1;
  assign dreq_size   = size_p1;
  assign dreq_strobe = (state_p1 == S_REQ) ? strobe_p1 : 8'd0;
  assign dreq_data   = data_p1;

  assign wb_valid    = (state_p1 == S_DONE) && !flush;
  assign wb_data     = wb_data_p2;
  assign wb_rd       = wb_rd_p2;
  assign wb_misalign = misalign_p2;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: NONE/load/store ops, bus stalls, misalignment,
// flush during the handshake and asynchronous reset mid-request.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] alu_c;
  logic [63:0] st_data;
  logic [1:0]  mem_kind;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [4:0]  rd;
  logic        flush;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        wb_valid;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_misalign;

  int checks = 0;
  int errors = 0;

  mem_access #(.REG_W(5), .ADDR_W(64)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_c(alu_c), .st_data(st_data), .mem_kind(mem_kind), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .rd(rd), .flush(flush),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_misalign(wb_misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] kind, input logic [1:0] sz, input logic uns,
                       input logic [63:0] addr, input logic [63:0] sd, input logic [4:0] r);
    mem_kind = kind; mem_size = sz; mem_unsigned = uns;
    alu_c = addr; st_data = sd; rd = r; ex_valid = 1'b1;
    tick();
    ex_valid = 1'b0;
    #1;
  endtask

  task automatic load_op(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [63:0] addr, input logic [63:0] resp, input logic [63:0] exp);
    issue(2'd1, sz, uns, addr, 64'd0, 5'd9);
    check({tag, "_req_valid"}, 64'(dreq_valid), 64'd1);
    check({tag, "_req_addr"}, dreq_addr, addr);
    check({tag, "_req_strobe"}, 64'(dreq_strobe), 64'd0);
    dresp_data = resp; dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 64'd0;
    #1;
    check({tag, "_wb_valid"}, 64'(wb_valid), 64'd1);
    check({tag, "_wb_data"}, wb_data, exp);
    check({tag, "_wb_rd"}, 64'(wb_rd), 64'd9);
    tick();
    check({tag, "_wb_off"}, 64'(wb_valid), 64'd0);
  endtask

  task automatic store_op(input string tag, input logic [1:0] sz, input logic [63:0] addr,
                          input logic [63:0] sd, input logic [7:0] exp_strb, input logic [63:0] exp_data);
    issue(2'd2, sz, 1'b0, addr, sd, 5'd4);
    check({tag, "_strobe"}, 64'(dreq_strobe), 64'(exp_strb));
    check({tag, "_data"}, dreq_data, exp_data);
    dresp_addr_ok = 1'b1; dresp_data_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0;
    #1;
    check({tag, "_wb_valid"}, 64'(wb_valid), 64'd1);
    check({tag, "_wb_data"}, wb_data, 64'd0);
    tick();
  endtask

  initial begin
    reset = 1'b0; ex_valid = 1'b0; alu_c = 64'd0; st_data = 64'd0;
    mem_kind = 2'd0; mem_size = 2'd0; mem_unsigned = 1'b0; rd = 5'd0; flush = 1'b0;
    dresp_addr_ok = 1'b0; dresp_data_ok = 1'b0; dresp_data = 64'd0;
    #3;
    check("rst_ex_ready", 64'(ex_ready), 64'd1);
    check("rst_dreq_valid", 64'(dreq_valid), 64'd0);
    check("rst_strobe", 64'(dreq_strobe), 64'd0);
    check("rst_wb_valid", 64'(wb_valid), 64'd0);
    check("rst_misalign", 64'(wb_misalign), 64'd0);
    check("rst_wb_data", wb_data, 64'd0);
    check("rst_wb_rd", 64'(wb_rd), 64'd0);
    @(negedge clk); reset = 1'b1;
    tick();

    // NONE op: one-cycle latency, ex_ready low during DONE
    issue(2'd0, 2'd3, 1'b0, 64'h1234, 64'd0, 5'd5);
    check("none_wb_valid", 64'(wb_valid), 64'd1);
    check("none_wb_data", wb_data, 64'h1234);
    check("none_wb_rd", 64'(wb_rd), 64'd5);
    check("none_ex_ready", 64'(ex_ready), 64'd0);
    check("none_dreq_valid", 64'(dreq_valid), 64'd0);
    tick();
    check("none_idle_wb", 64'(wb_valid), 64'd0);
    check("none_idle_ready", 64'(ex_ready), 64'd1);

    // reserved kind behaves as NONE
    issue(2'd3, 2'd0, 1'b0, 64'h55AA, 64'd0, 5'd6);
    check("rsv_wb_valid", 64'(wb_valid), 64'd1);
    check("rsv_wb_data", wb_data, 64'h55AA);
    tick();

    load_op("lb_s", 2'd0, 1'b0, 64'h1003, 64'h00000000_80000000, 64'hFFFF_FFFF_FFFF_FF80);
    load_op("lb_u", 2'd0, 1'b1, 64'h1003, 64'h00000000_80000000, 64'h0000_0000_0000_0080);
    load_op("lh_s", 2'd1, 1'b0, 64'h0002, 64'h00000000_80010000, 64'hFFFF_FFFF_FFFF_8001);
    load_op("lw_s", 2'd2, 1'b0, 64'h0004, 64'h89ABCDEF_01234567, 64'hFFFF_FFFF_89AB_CDEF);
    load_op("lw_u", 2'd2, 1'b1, 64'h0004, 64'h89ABCDEF_01234567, 64'h0000_0000_89AB_CDEF);
    load_op("ld",   2'd3, 1'b1, 64'h0008, 64'hDEADBEEF_CAFEF00D, 64'hDEADBEEF_CAFEF00D);

    store_op("sb", 2'd0, 64'h0105, 64'h0000_0000_0000_00A5, 8'h20, 64'h0000_A500_0000_0000);
    store_op("sw", 2'd2, 64'h0004, 64'h0000_0000_1122_3344, 8'hF0, 64'h1122_3344_0000_0000);
    store_op("sd", 2'd3, 64'h0010, 64'h0102_0304_0506_0708, 8'hFF, 64'h0102_0304_0506_0708);

    // SH with addr_ok held low: request fields stay stable
    issue(2'd2, 2'd1, 1'b0, 64'h2006, 64'hABCD, 5'd3);
    for (int i = 0; i < 3; i++) begin
      check("sh_hold_valid", 64'(dreq_valid), 64'd1);
      check("sh_hold_addr", dreq_addr, 64'h2006);
      check("sh_hold_size", 64'(dreq_size), 64'd1);
      check("sh_hold_strobe", 64'(dreq_strobe), 64'hC0);
      check("sh_hold_data", dreq_data, 64'hABCD_0000_0000_0000);
      tick();
    end
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0;
    #1;
    check("sh_wait_valid", 64'(dreq_valid), 64'd0);
    check("sh_wait_wb", 64'(wb_valid), 64'd0);
    check("sh_wait_ready", 64'(ex_ready), 64'd0);
    dresp_data_ok = 1'b1;
    tick();
    dresp_data_ok = 1'b0;
    #1;
    check("sh_wb_valid", 64'(wb_valid), 64'd1);
    check("sh_wb_data", wb_data, 64'd0);
    check("sh_wb_rd", 64'(wb_rd), 64'd3);
    tick();

    // Misaligned LW: no bus request, misalign writeback next cycle
    issue(2'd1, 2'd2, 1'b0, 64'h2002, 64'd0, 5'd8);
    check("mis_dreq_valid", 64'(dreq_valid), 64'd0);
    check("mis_wb_valid", 64'(wb_valid), 64'd1);
    check("mis_flag", 64'(wb_misalign), 64'd1);
    check("mis_wb_data", wb_data, 64'h2002);
    tick();
    check("mis_idle_ready", 64'(ex_ready), 64'd1);
    check("mis_idle_dreq", 64'(dreq_valid), 64'd0);

    // Flush in IDLE blocks the transfer
    alu_c = 64'h77; mem_kind = 2'd0; ex_valid = 1'b1; flush = 1'b1;
    #1;
    check("fidle_ready", 64'(ex_ready), 64'd0);
    tick();
    ex_valid = 1'b0; flush = 1'b0;
    #1;
    check("fidle_wb", 64'(wb_valid), 64'd0);
    check("fidle_ready2", 64'(ex_ready), 64'd1);

    // Flush in WAIT: handshake completes, no writeback
    issue(2'd1, 2'd3, 1'b0, 64'h3000, 64'd0, 5'd10);
    dresp_addr_ok = 1'b1;
    tick();
    dresp_addr_ok = 1'b0; flush = 1'b1;
    #1;
    check("fwait_wb1", 64'(wb_valid), 64'd0);
    tick();
    flush = 1'b0;
    #1;
    check("fwait_wb2", 64'(wb_valid), 64'd0);
    check("fwait_busy", 64'(ex_ready), 64'd0);
    tick();
    dresp_data_ok = 1'b1; dresp_data = 64'h1111;
    tick();
    dresp_data_ok = 1'b0;
    #1;
    check("fwait_wb3", 64'(wb_valid), 64'd0);
    check("fwait_ready", 64'(ex_ready), 64'd1);
    tick();
    check("fwait_wb4", 64'(wb_valid), 64'd0);

    // Asynchronous reset while in REQ
    issue(2'd1, 2'd3, 1'b0, 64'h5008, 64'd0, 5'd12);
    check("arst_pre_valid", 64'(dreq_valid), 64'd1);
    #1 reset = 1'b0;
    #1;
    check("arst_dreq_valid", 64'(dreq_valid), 64'd0);
    check("arst_ex_ready", 64'(ex_ready), 64'd1);
    @(negedge clk); reset = 1'b1;
    tick();
    load_op("ld_post_rst", 2'd3, 1'b0, 64'h5008, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
